// File: rtl/fc_input_collector.sv
// fc_input_collector: assembles a flattened activation stream into a held parallel vector for an FC layer
//   clk, rst                   clock, asynchronous active-high reset
//   in_data/in_valid/in_last   element stream, element 0 first; in_ready is the handshake back
//   x[0:IN-1], x_valid         assembled frame, stable while x_valid=1
//   x_ack                      consumer done with x; return to collecting
//   len_err                    one-cycle pulse when in_last disagrees with the frame length
module fc_input_collector #(
  parameter int WIDTH = 8,
  parameter int IN    = 400
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] x [0:IN-1],
  output logic             x_valid,
  input  logic             x_ack,
  output logic             len_err
);
  localparam int IW = $clog2(IN);
  typedef enum logic {FILL, HOLD} state_t;
  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            len_err_q, len_err_d;
  logic [WIDTH-1:0] x_q [0:IN-1];
  logic            accept, at_end;
  assign accept = in_valid & in_ready;
  assign at_end = idx_q == IW'(IN - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q   <= FILL;
      idx_q     <= '0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      len_err_q <= len_err_d;
    end
  // Length error: a full frame without in_last, or in_last before the frame is full.
  // Either case restarts collection at element 0.
  always_comb begin
    state_d   = (accept && at_end) ? HOLD : (state_q == HOLD && x_ack) ? FILL : state_q;
    idx_d     = accept ? ((at_end || in_last) ? '0 : idx_q + IW'(1)) : idx_q;
    len_err_d = accept && (at_end ? !in_last : in_last);
  end
  // in_ready is gated by rst directly so no beat is offered during reset.
  always_comb begin
    in_ready = (state_q == FILL) && !rst;
    x_valid  = state_q == HOLD;
    len_err  = len_err_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < IN; i++) x_q[i] <= '0;
    end else if (accept) begin
      x_q[idx_q] <= in_data;
    end
  assign x = x_q;
endmodule

// File: tb/tb_fc_input_collector.sv
// tb_fc_input_collector: randomized scoreboard bench for fc_input_collector
module tb_fc_input_collector;
  localparam int WIDTH = 8;
  localparam int IN    = 400;
  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_last = 1'b0;
  logic             x_ack = 1'b0;
  logic             in_ready, x_valid, len_err;
  logic [WIDTH-1:0] x [0:IN-1];
  fc_input_collector #(.WIDTH(WIDTH), .IN(IN)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .x(x), .x_valid(x_valid), .x_ack(x_ack), .len_err(len_err)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int n_checks = 0;
  int n_fail = 0;
  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // Reference model: a frame is a list of accepted elements; it ends on in_last or
  // when it reaches IN elements. Every ending produces one observable event one cycle later.
  typedef struct { int due; bit frame; bit err; } ev_t;
  ev_t              evq[$];
  logic [WIDTH-1:0] fdata[$];
  logic [WIDTH-1:0] cur[$];
  logic [WIDTH-1:0] held [IN];
  task automatic model_accept(logic [WIDTH-1:0] d, logic last);
    ev_t e;
    cur.push_back(d);
    if (last || cur.size() == IN) begin
      e.due   = cyc + 1;
      e.frame = cur.size() == IN;
      e.err   = (cur.size() != IN) || !last;
      if (e.frame) foreach (cur[i]) fdata.push_back(cur[i]);
      evq.push_back(e);
      cur.delete();
    end
  endtask
  // Monitor: pops an expected event whenever x_valid rises or len_err pulses.
  logic xv_prev = 1'b0;
  always @(negedge clk) begin
    if (rst) xv_prev = 1'b0;
    else begin
      bit rise;
      rise = x_valid && !xv_prev;
      while (evq.size() != 0 && evq[0].due < cyc) begin
        ev_t m;
        m = evq.pop_front();
        chk("event_seen", 0, 1);
        if (m.frame) repeat (IN) void'(fdata.pop_front());
      end
      if (rise || len_err) begin
        if (evq.size() == 0) chk("unexpected_event", {30'd0, rise, len_err}, 0);
        else begin
          ev_t e;
          int bad;
          e = evq.pop_front();
          chk("event_cycle", cyc, e.due);
          chk("x_valid_rise", int'(rise), int'(e.frame));
          chk("len_err", int'(len_err), int'(e.err));
          if (e.frame) begin
            bad = 0;
            for (int i = 0; i < IN; i++) begin
              held[i] = fdata.pop_front();
              if (x[i] !== held[i]) bad++;
            end
            chk("frame_data_bad_elems", bad, 0);
          end
        end
      end
      xv_prev = x_valid;
    end
  end
  // Sends beats until n are accepted; in_last goes with accepted beat last_at (-1: never).
  task automatic drive_frame(int n, int last_at, bit rnd, int base);
    int k = 0;
    int guard = 0;
    while (k < n) begin
      @(negedge clk);
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = rnd ? WIDTH'($urandom) : WIDTH'(base + k);
      in_last  = k == last_at;
      if (in_valid && in_ready) begin
        model_accept(in_data, in_last);
        k++;
      end
      guard++;
      if (guard > 20 * n + 100) begin
        chk("accept_timeout", k, n);
        break;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask
  function automatic int held_diff();
    int bad = 0;
    for (int i = 0; i < IN; i++) if (x[i] !== held[i]) bad++;
    return bad;
  endfunction
  // Waits for x_valid, optionally stresses HOLD with incoming beats, then acknowledges.
  task automatic release_frame(int stress);
    int w = 0;
    while (!x_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("x_valid_high", int'(x_valid), 1);
    chk("in_ready_in_hold", int'(in_ready), 0);
    for (int c = 0; c < stress; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = WIDTH'($urandom);
      in_last  = 1'($urandom_range(0, 1));
    end
    if (stress > 0) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      chk("hold_frozen_bad_elems", held_diff(), 0);
      chk("hold_x_valid", int'(x_valid), 1);
    end
    @(negedge clk);
    x_ack = 1'b1;
    @(negedge clk);
    x_ack = 1'b0;
    chk("ack_x_valid_low", int'(x_valid), 0);
    chk("ack_in_ready_high", int'(in_ready), 1);
  endtask
  int zeros;
  initial begin
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_x_valid", int'(x_valid), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_len_err", int'(len_err), 0);
    zeros = 0;
    for (int i = 0; i < IN; i++) if (x[i] !== '0) zeros++;
    chk("rst_x_nonzero", zeros, 0);
    foreach (held[i]) held[i] = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", int'(in_ready), 1);
    // ack in FILL has no effect
    x_ack = 1'b1;
    @(negedge clk);
    x_ack = 1'b0;
    @(negedge clk);
    chk("ack_in_fill_x_valid", int'(x_valid), 0);
    chk("ack_in_fill_in_ready", int'(in_ready), 1);
    // full frame with data i[7:0], then hold stress and release
    drive_frame(IN, IN - 1, 1'b0, 0);
    release_frame(10);
    // early last on beat 99 followed by a clean frame
    drive_frame(100, 99, 1'b0, 8'h55);
    repeat (3) @(negedge clk);
    chk("early_last_x_valid", int'(x_valid), 0);
    chk("early_last_in_ready", int'(in_ready), 1);
    drive_frame(IN, IN - 1, 1'b0, 8'h80);
    release_frame(0);
    // full frame with no in_last
    drive_frame(IN, -1, 1'b0, 8'h13);
    release_frame(0);
    // random valid gaps and random data
    drive_frame(IN, IN - 1, 1'b1, 0);
    release_frame(3);
    for (int r = 0; r < 3; r++) begin
      int len;
      len = $urandom_range(1, IN);
      drive_frame(len, len - 1, 1'b1, 0);
      if (len == IN) release_frame(0);
    end
    // async reset in the middle of a frame
    drive_frame(250, -1, 1'b1, 0);
    #2 rst = 1'b1;
    #1;
    cur.delete();
    foreach (held[i]) held[i] = '0;
    chk("midrst_x_valid", int'(x_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 0);
    chk("midrst_x_nonzero", held_diff(), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    drive_frame(IN, IN - 1, 1'b1, 0);
    release_frame(0);
    repeat (5) @(negedge clk);
    chk("events_pending", evq.size(), 0);
    chk("len_err_idle", int'(len_err), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
